// File: rtl/aes_stream_ctrl.sv
// Streaming wrapper around a free-running fixed-latency AES-128 core: ready/valid on both
// sides, tag tracking through the core pipeline, credit admission and a lossless output FIFO.
module aes_stream_ctrl #(
  parameter int DATA_W  = 128,
  parameter int TAG_W   = 4,
  parameter int LATENCY = 21,
  parameter int DEPTH   = 32,
  parameter int CNT_W   = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_state,
  input  logic [DATA_W-1:0] in_key,
  input  logic [TAG_W-1:0]  in_tag,
  output logic [DATA_W-1:0] core_state,
  output logic [DATA_W-1:0] core_key,
  input  logic [DATA_W-1:0] core_out,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [TAG_W-1:0]  out_tag,
  output logic              busy,
  output logic [CNT_W-1:0]  done_cnt
);

  localparam int AW    = $clog2(DEPTH);
  localparam int OCC_W = $clog2(DEPTH + LATENCY + 1);
  localparam logic [OCC_W-1:0] DEPTH_C = OCC_W'(DEPTH);

  logic              w_acc;
  logic              w_arrive;
  logic              w_push;
  logic              w_pop;
  logic [OCC_W-1:0]  w_occ;

  logic [LATENCY-1:0] r_vld;
  logic [TAG_W-1:0]   r_tag [LATENCY];
  logic [OCC_W-1:0]   r_inflight;
  logic [OCC_W-1:0]   r_count;
  logic [AW-1:0]      r_wptr;
  logic [AW-1:0]      r_rptr;
  logic [DATA_W-1:0]  r_mem_data [DEPTH];
  logic [TAG_W-1:0]   r_mem_tag  [DEPTH];
  logic [CNT_W-1:0]   r_done;

  // Admission credit comes only from registered occupancy, so every block already
  // accepted is guaranteed a FIFO slot by the time it leaves the core.
  assign w_occ      = r_inflight + r_count;
  assign in_ready   = (w_occ < DEPTH_C);
  assign w_acc      = in_valid & in_ready;
  assign core_state = w_acc ? in_state : '0;
  assign core_key   = w_acc ? in_key   : '0;

  assign w_arrive  = r_vld[LATENCY-1];
  assign w_push    = w_arrive;
  assign out_valid = (r_count != '0);
  assign w_pop     = out_valid & out_ready;
  assign out_data  = out_valid ? r_mem_data[r_rptr] : '0;
  assign out_tag   = out_valid ? r_mem_tag[r_rptr]  : '0;
  assign busy      = (w_occ != '0);
  assign done_cnt  = r_done;

  // Core-side tracking: valid bits mirror the core pipeline, zero-block cycles carry 0
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_vld <= '0;
    end else begin
      r_vld[0] <= w_acc;
      for (int i = 1; i < LATENCY; i++) r_vld[i] <= r_vld[i-1];
    end
  end

  always_ff @(posedge clk) begin
    r_tag[0] <= in_tag;
    for (int i = 1; i < LATENCY; i++) r_tag[i] <= r_tag[i-1];
  end

  // Output FIFO storage
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_data[r_wptr] <= core_out;
      r_mem_tag[r_wptr]  <= r_tag[LATENCY-1];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_inflight <= '0;
      r_done     <= '0;
    end else begin
      r_wptr     <= r_wptr + AW'(w_push);
      r_rptr     <= r_rptr + AW'(w_pop);
      r_count    <= r_count + OCC_W'(w_push) - OCC_W'(w_pop);
      r_inflight <= r_inflight + OCC_W'(w_acc) - OCC_W'(w_arrive);
      if (w_pop && (r_done != '1)) r_done <= r_done + CNT_W'(1);
    end
  end

  arrive_into_full: assert property (@(posedge clk) disable iff (!reset)
    !(w_arrive && (r_count == DEPTH_C)));

endmodule

// File: tb/tb_aes_stream_ctrl.sv
// Self-checking bench for aes_stream_ctrl: behavioural AES-128 core model, table vectors,
// corner-case sequences and randomized traffic against a queue-based reference.
module tb_aes_stream_ctrl;
  localparam int DATA_W  = 128;
  localparam int TAG_W   = 4;
  localparam int LATENCY = 21;
  localparam int DEPTH   = 32;
  localparam int CNT_W   = 3;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              reset;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_state;
  logic [DATA_W-1:0] in_key;
  logic [TAG_W-1:0]  in_tag;
  logic [DATA_W-1:0] core_state;
  logic [DATA_W-1:0] core_key;
  logic [DATA_W-1:0] core_out;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [TAG_W-1:0]  out_tag;
  logic              busy;
  logic [CNT_W-1:0]  done_cnt;

  always #5 clk = ~clk;

  aes_stream_ctrl #(
    .DATA_W(DATA_W), .TAG_W(TAG_W), .LATENCY(LATENCY), .DEPTH(DEPTH), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_state(in_state), .in_key(in_key), .in_tag(in_tag),
    .core_state(core_state), .core_key(core_key), .core_out(core_out),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_tag(out_tag),
    .busy(busy), .done_cnt(done_cnt)
  );

  // AES-128 reference
  logic [7:0] sbox [256];

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  task automatic init_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]} ^
                {inv[3:0], inv[7:4]} ^ 8'h63;
    end
  endtask

  function automatic logic [127:0] aes128(input logic [127:0] pt, input logic [127:0] key);
    logic [7:0] s [16];
    logic [7:0] k [16];
    logic [7:0] t [16];
    logic [7:0] a0, a1, a2, a3, rc;
    logic [127:0] res;
    for (int i = 0; i < 16; i++) begin
      s[i] = pt[127-8*i -: 8];
      k[i] = key[127-8*i -: 8];
      s[i] = s[i] ^ k[i];
    end
    rc = 8'h01;
    for (int r = 1; r <= 10; r++) begin
      a0 = sbox[k[13]] ^ rc;
      a1 = sbox[k[14]];
      a2 = sbox[k[15]];
      a3 = sbox[k[12]];
      k[0] = k[0] ^ a0; k[1] = k[1] ^ a1; k[2] = k[2] ^ a2; k[3] = k[3] ^ a3;
      for (int i = 4; i < 16; i++) k[i] = k[i] ^ k[i-4];
      rc = xt(rc);
      for (int i = 0; i < 16; i++) s[i] = sbox[s[i]];
      for (int c = 0; c < 4; c++)
        for (int rr = 0; rr < 4; rr++) t[4*c+rr] = s[4*((c+rr)%4)+rr];
      for (int c = 0; c < 4; c++) begin
        a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
        if (r != 10) begin
          s[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
          s[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
          s[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
          s[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
        end else begin
          s[4*c] = a0; s[4*c+1] = a1; s[4*c+2] = a2; s[4*c+3] = a3;
        end
      end
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ k[i];
    end
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
    return res;
  endfunction

  // Free-running core: no reset, so stale results keep flowing after a controller reset
  logic [127:0] core_pipe [LATENCY];
  always @(posedge clk) begin
    core_pipe[0] <= aes128(core_state, core_key);
    for (int i = 1; i < LATENCY; i++) core_pipe[i] <= core_pipe[i-1];
  end
  assign core_out = core_pipe[LATENCY-1];

  typedef struct {
    logic [127:0] st;
    logic [127:0] key;
    logic [3:0]   tag;
    logic [127:0] exp;
  } vec_t;
  vec_t vec [6];

  typedef struct {
    logic [127:0] data;
    logic [3:0]   tag;
    int           acyc;
  } exp_t;
  exp_t q [$];

  logic [127:0] log_d [$];
  logic [3:0]   log_t [$];
  int           log_c [$];
  int           cyc, pops_m, dut_acc, a0, errors, checks;
  logic [127:0] drv_exp, st, ky;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic set_in(input bit v, input logic [127:0] s, input logic [127:0] k,
                        input logic [3:0] tg, input logic [127:0] ex);
    in_valid = v;
    in_state = s;
    in_key   = k;
    in_tag   = tg;
    drv_exp  = ex;
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // One clock cycle: compare against the reference, then advance it by this cycle's events
  task automatic tick();
    bit m_rdy, m_ov, acc, pop;
    logic [127:0] m_data;
    logic [3:0] m_tag;
    exp_t e;
    #1;
    m_rdy  = (q.size() < DEPTH);
    m_ov   = (q.size() > 0) && (cyc >= q[0].acyc + LATENCY + 1);
    m_data = m_ov ? q[0].data : 128'h0;
    m_tag  = m_ov ? q[0].tag : 4'h0;
    chk("in_ready", 128'(in_ready), 128'(m_rdy));
    chk("out_valid", 128'(out_valid), 128'(m_ov));
    chk("out_data", out_data, m_data);
    chk("out_tag", 128'(out_tag), 128'(m_tag));
    chk("busy", 128'(busy), 128'(q.size() != 0));
    chk("done_cnt", 128'(done_cnt), 128'((pops_m > CNT_MAX) ? CNT_MAX : pops_m));
    if (in_valid && in_ready) dut_acc++;
    acc = in_valid && m_rdy;
    pop = m_ov && out_ready;
    if (pop) begin
      log_d.push_back(out_data);
      log_t.push_back(out_tag);
      log_c.push_back(cyc);
      void'(q.pop_front());
      pops_m++;
    end
    if (acc) begin
      e.data = drv_exp;
      e.tag  = in_tag;
      e.acyc = cyc;
      q.push_back(e);
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic drain(input int budget);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < budget && q.size() != 0; i++) tick();
    chk("drain_in_budget", 128'(q.size()), 128'(0));
    tick();
  endtask

  task automatic clear_log();
    log_d.delete();
    log_t.delete();
    log_c.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    errors = 0; checks = 0; cyc = 0; pops_m = 0; dut_acc = 0;
    init_sbox();
    for (int i = 0; i < LATENCY; i++) core_pipe[i] = '0;
    reset = 1'b0; out_ready = 1'b0;
    set_in(1'b0, '0, '0, '0, '0);

    vec[0] = '{128'h3243f6a8885a308d313198a2e0370734, 128'h2b7e151628aed2a6abf7158809cf4f3c,
               4'd5, 128'h3925841d02dc09fbdc118597196a0b32};
    vec[1] = '{128'h3243f6a8885a308d313198a2e0370734, 128'h2b7e151628aed2a6abf7158809cf4f3c,
               4'd1, 128'h3925841d02dc09fbdc118597196a0b32};
    vec[2] = '{128'h00112233445566778899aabbccddeeff, 128'h000102030405060708090a0b0c0d0e0f,
               4'd2, 128'h69c4e0d86a7b0430d8cdb78070b4c55a};
    vec[3] = '{128'h0, 128'h0, 4'd3, 128'h66e94bd4ef8a2c3b884cfa59ca342b2e};
    vec[4] = '{128'h0, 128'h1, 4'd4, 128'h0545aad56da2a97c3663d1432a3d1c84};
    vec[5] = '{128'h1, 128'h0, 4'd5, 128'h58e2fccefa7e3061367f1d57a4e7455a};

    repeat (3) @(negedge clk);
    #1;
    chk("reset_out_valid", 128'(out_valid), 128'(0));
    chk("reset_out_data", out_data, 128'h0);
    chk("reset_out_tag", 128'(out_tag), 128'(0));
    chk("reset_busy", 128'(busy), 128'(0));
    chk("reset_done_cnt", 128'(done_cnt), 128'(0));
    @(negedge clk);
    reset = 1'b1;
    tick();

    // Single known-answer block
    out_ready = 1'b1;
    clear_log();
    a0 = cyc;
    set_in(1'b1, vec[0].st, vec[0].key, vec[0].tag, vec[0].exp);
    tick();
    in_valid = 1'b0;
    drain(60);
    chk("single_count", 128'(log_d.size()), 128'(1));
    if (log_d.size() >= 1) begin
      chk("single_data", log_d[0], vec[0].exp);
      chk("single_tag", 128'(log_t[0]), 128'(vec[0].tag));
      chk("single_latency", 128'(log_c[0] - a0), 128'(LATENCY + 1));
    end
    chk("single_done_cnt", 128'(done_cnt), 128'(1));

    // Back-to-back stream from the vector table
    clear_log();
    a0 = cyc;
    for (int i = 1; i < 6; i++) begin
      set_in(1'b1, vec[i].st, vec[i].key, vec[i].tag, vec[i].exp);
      tick();
    end
    drain(80);
    chk("stream_count", 128'(log_d.size()), 128'(5));
    if (log_d.size() == 5) begin
      for (int i = 1; i < 6; i++) begin
        chk("stream_data", log_d[i-1], vec[i].exp);
        chk("stream_tag", 128'(log_t[i-1]), 128'(vec[i].tag));
        chk("stream_timing", 128'(log_c[i-1] - a0), 128'(LATENCY + i));
      end
    end

    // Backpressure: consumer stalled while the host keeps offering
    out_ready = 1'b0;
    dut_acc = 0;
    for (int i = 0; i < DEPTH + LATENCY + 8; i++) begin
      st = rnd128(); ky = rnd128();
      set_in(1'b1, st, ky, 4'($urandom()), aes128(st, ky));
      tick();
    end
    chk("bp_accepted", 128'(dut_acc), 128'(DEPTH));
    chk("bp_in_ready_low", 128'(in_ready), 128'(0));
    clear_log();
    drain(DEPTH + LATENCY + 20);
    chk("bp_drained", 128'(log_d.size()), 128'(DEPTH));
    chk("bp_in_ready_back", 128'(in_ready), 128'(1));

    // Gaps between offers: idle cycles inject zero blocks that must stay invisible
    clear_log();
    for (int i = 0; i < 20; i++) begin
      st = rnd128(); ky = rnd128();
      set_in(bit'(i % 2 == 0), st, ky, 4'($urandom()), aes128(st, ky));
      tick();
    end
    drain(60);
    chk("gap_count", 128'(log_d.size()), 128'(10));
    chk("gap_busy", 128'(busy), 128'(0));

    // Asynchronous reset with results buffered and ten blocks still in the core
    out_ready = 1'b0;
    for (int i = 0; i < 25; i++) begin
      st = rnd128(); ky = rnd128();
      set_in(1'b1, st, ky, 4'($urandom()), aes128(st, ky));
      tick();
    end
    in_valid = 1'b0;
    repeat (11) tick();
    chk("pre_reset_out_valid", 128'(out_valid), 128'(1));
    #2;
    reset = 1'b0;
    #1;
    chk("async_out_valid", 128'(out_valid), 128'(0));
    chk("async_busy", 128'(busy), 128'(0));
    chk("async_done_cnt", 128'(done_cnt), 128'(0));
    chk("async_out_data", out_data, 128'h0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    q.delete();
    pops_m = 0;
    clear_log();
    out_ready = 1'b1;
    st = rnd128(); ky = rnd128();
    set_in(1'b1, st, ky, 4'd9, aes128(st, ky));
    tick();
    drain(60);
    chk("post_reset_count", 128'(log_d.size()), 128'(1));
    if (log_d.size() >= 1) begin
      chk("post_reset_data", log_d[0], aes128(st, ky));
      chk("post_reset_tag", 128'(log_t[0]), 128'(9));
    end

    // Counter saturation at 2^CNT_W-1
    for (int i = 0; i < 9; i++) begin
      st = rnd128(); ky = rnd128();
      set_in(1'b1, st, ky, 4'(i), aes128(st, ky));
      tick();
    end
    drain(60);
    chk("sat_done_cnt", 128'(done_cnt), 128'(CNT_MAX));
    repeat (3) tick();
    chk("sat_hold", 128'(done_cnt), 128'(CNT_MAX));

    // Randomized traffic with periodic consumer stalls
    for (int i = 0; i < 1500; i++) begin
      st = rnd128(); ky = rnd128();
      set_in(bit'(($urandom() % 4) != 0), st, ky, 4'($urandom()), aes128(st, ky));
      out_ready = ((i / 100) % 3 == 2) ? 1'b0 : bit'(($urandom() % 8) < 5);
      tick();
    end
    drain(DEPTH + LATENCY + 40);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
